sync_fifo_param: RTL and testbench

//  Parametrised single-clock FIFO; successor to the fixed 16x32 buffer block.

---
 rtl/fifo_pkg.sv | 46 ++++
 rtl/sync_fifo_param_if.sv | 37 +++
 rtl/fifo_mem_2p.sv | 61 ++++++
 rtl/sync_fifo_param.sv | 144 ++++++++++++++
 tb/tb_sync_fifo_param.sv | 249 ++++++++++++++++++++++++
 5 files changed

// File: rtl/fifo_pkg.sv
// fifo_pkg
//   Shared definitions for the FIFO family: default geometry, a registered
//   status-flag bundle with its post-reset value, and elaboration-time helper
//   functions (clog2, threshold range check) meant to be reused by the
//   upcoming async FIFO.
package fifo_pkg;

  localparam int DEFAULT_DATA_W = 16;
  localparam int DEFAULT_ADDR_W = 5;

  // Occupancy-derived status flags, kept together so they are registered
  // from the same next-count value on the same edge.
  typedef struct packed {
    logic full;
    logic empty;
    logic almost_full;
    logic almost_empty;
  } fifo_flags_t;

  // With a legal threshold pair an empty FIFO is always almost_empty and
  // never almost_full, so this value holds for every configuration.
  localparam fifo_flags_t FIFO_FLAGS_EMPTY = '{
    full:         1'b0,
    empty:        1'b1,
    almost_full:  1'b0,
    almost_empty: 1'b1
  };

  function automatic int clog2(input int value);
    int result;
    result = 0;
    while ((1 << result) < value) begin
      result++;
    end
    return result;
  endfunction

  // almost_full must be reachable and not trivially true (1..depth);
  // almost_empty must not be trivially true at full (0..depth-1).
  function automatic bit thresholds_ok(input int depth, input int afull_th,
                                       input int aempty_th);
    return (afull_th >= 1) && (afull_th <= depth) &&
           (aempty_th >= 0) && (aempty_th <= depth - 1);
  endfunction

endpackage

// File: rtl/sync_fifo_param_if.sv
// sync_fifo_param_if
//   Producer/consumer handshake bundle of the parametrised synchronous FIFO.
//   master: the datapath side (drives flush, wr_en, wr_data, rd_en).
//   slave:  the FIFO itself (drives rd_data, rd_valid, status and errors).
//   clk and rst are not part of the bundle; they stay plain module ports.
interface sync_fifo_param_if import fifo_pkg::*; #(
  parameter int DATA_W = DEFAULT_DATA_W,
  parameter int ADDR_W = DEFAULT_ADDR_W
);

  logic              flush;
  logic              wr_en;
  logic [DATA_W-1:0] wr_data;
  logic              rd_en;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;
  logic              full;
  logic              empty;
  logic              almost_full;
  logic              almost_empty;
  logic [ADDR_W:0]   count;
  logic              overflow;
  logic              underflow;

  modport master (
    output flush, wr_en, wr_data, rd_en,
    input  rd_data, rd_valid, full, empty, almost_full, almost_empty,
           count, overflow, underflow
  );

  modport slave (
    input  flush, wr_en, wr_data, rd_en,
    output rd_data, rd_valid, full, empty, almost_full, almost_empty,
           count, overflow, underflow
  );

endinterface

// File: rtl/fifo_mem_2p.sv
// fifo_mem_2p
//   DEPTH x DATA_W storage with one write port and one read port.
//   FWFT=0: registered read, rd_data loads mem[rd_addr] on rd_en and holds
//           otherwise; cleared by rst.
//   FWFT=1: combinational read of mem[rd_addr]; rd_en/rst are not needed.
//   Ports: clk, rst, wr_en, wr_addr, wr_data, rd_en, rd_addr, rd_data.
//   Storage itself is never reset.
module fifo_mem_2p import fifo_pkg::*; #(
  parameter int DATA_W = DEFAULT_DATA_W,
  parameter int ADDR_W = DEFAULT_ADDR_W,
  parameter int FWFT   = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  generate
    if (FWFT != 0) begin : g_comb_read
      logic unused_ctrl;
      assign unused_ctrl = rd_en ^ rst;
      assign rd_data     = mem_q[rd_addr];
    end else begin : g_reg_read
      logic [DATA_W-1:0] rd_data_q;
      logic [DATA_W-1:0] rd_data_d;

      always_comb begin
        rd_data_d = rd_data_q;
        if (rd_en) begin
          rd_data_d = mem_q[rd_addr];
        end
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          rd_data_q <= '0;
        end else begin
          rd_data_q <= rd_data_d;
        end
      end

      assign rd_data = rd_data_q;
    end
  endgenerate

endmodule

// File: rtl/sync_fifo_param.sv
// sync_fifo_param
//   Parametrised single-clock FIFO between producer and consumer stages.
//   Holds read/write pointers, a separate occupancy counter, registered
//   status flags, sticky overflow/underflow errors and synchronous flush;
//   storage lives in fifo_mem_2p.
//   Ports: clk (rising edge), rst (async, active-high), bus (slave side of
//   sync_fifo_param_if: flush, wr_en, wr_data, rd_en in; rd_data, rd_valid,
//   full, empty, almost_full, almost_empty, count, overflow, underflow out).
module sync_fifo_param import fifo_pkg::*; #(
  parameter int DATA_W    = DEFAULT_DATA_W,
  parameter int ADDR_W    = DEFAULT_ADDR_W,
  parameter int FWFT      = 0,
  parameter int AFULL_TH  = 28,
  parameter int AEMPTY_TH = 4
) (
  input logic             clk,
  input logic             rst,
  sync_fifo_param_if.slave bus
);

  localparam int DEPTH = 2 ** ADDR_W;

  localparam logic [ADDR_W-1:0] PTR_ONE    = (ADDR_W)'(1);
  localparam logic [ADDR_W:0]   CNT_ONE    = (ADDR_W + 1)'(1);
  localparam logic [ADDR_W:0]   DEPTH_CNT  = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W:0]   AFULL_LVL  = (ADDR_W + 1)'(AFULL_TH);
  localparam logic [ADDR_W:0]   AEMPTY_LVL = (ADDR_W + 1)'(AEMPTY_TH);

  generate
    if (!thresholds_ok(DEPTH, AFULL_TH, AEMPTY_TH)) begin : g_bad_threshold
      $error("sync_fifo_param: AFULL_TH must be 1..DEPTH and AEMPTY_TH 0..DEPTH-1");
    end
  endgenerate

  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   count_q, count_d;
  fifo_flags_t       flags_q, flags_d;
  logic              overflow_q, overflow_d;
  logic              underflow_q, underflow_d;
  logic              rd_valid_q, rd_valid_d;

  logic wr_acc;
  logic rd_acc;
  logic mem_wr;
  logic mem_rd;

  // Acceptance looks only at the registered flags. Flush wins over both
  // requests, so neither the memory nor the read register may move then.
  always_comb begin
    wr_acc = bus.wr_en & ~flags_q.full;
    rd_acc = bus.rd_en & ~flags_q.empty;
    mem_wr = wr_acc & ~bus.flush;
    mem_rd = rd_acc & ~bus.flush;
  end

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;
    rd_valid_d  = 1'b0;
    if (bus.flush) begin
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      count_d     = '0;
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
    end else begin
      if (wr_acc) begin
        wr_ptr_d = wr_ptr_q + PTR_ONE;
      end
      if (rd_acc) begin
        rd_ptr_d = rd_ptr_q + PTR_ONE;
      end
      // Simultaneous accepted read and write leave occupancy unchanged.
      case ({wr_acc, rd_acc})
        2'b10:   count_d = count_q + CNT_ONE;
        2'b01:   count_d = count_q - CNT_ONE;
        default: count_d = count_q;
      endcase
      // Errors key on the raw request, not the accepted one.
      overflow_d  = overflow_q | (bus.wr_en & flags_q.full);
      underflow_d = underflow_q | (bus.rd_en & flags_q.empty);
      rd_valid_d  = rd_acc;
    end
  end

  // Flags come from next-count so they switch on the same edge as count.
  always_comb begin
    flags_d              = FIFO_FLAGS_EMPTY;
    flags_d.full         = (count_d == DEPTH_CNT);
    flags_d.empty        = (count_d == '0);
    flags_d.almost_full  = (count_d >= AFULL_LVL);
    flags_d.almost_empty = (count_d <= AEMPTY_LVL);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      flags_q     <= FIFO_FLAGS_EMPTY;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
      rd_valid_q  <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      flags_q     <= flags_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
      rd_valid_q  <= rd_valid_d;
    end
  end

  fifo_mem_2p #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .FWFT   (FWFT)
  ) u_mem (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (mem_wr),
    .wr_addr (wr_ptr_q),
    .wr_data (bus.wr_data),
    .rd_en   (mem_rd),
    .rd_addr (rd_ptr_q),
    .rd_data (bus.rd_data)
  );

  // In fall-through mode the head word is valid whenever anything is stored.
  assign bus.rd_valid     = (FWFT != 0) ? ~flags_q.empty : rd_valid_q;
  assign bus.full         = flags_q.full;
  assign bus.empty        = flags_q.empty;
  assign bus.almost_full  = flags_q.almost_full;
  assign bus.almost_empty = flags_q.almost_empty;
  assign bus.count        = count_q;
  assign bus.overflow     = overflow_q;
  assign bus.underflow    = underflow_q;

endmodule

// File: tb/tb_sync_fifo_param.sv
// tb_sync_fifo_param
//   Bench for sync_fifo_param: one registered-read instance driven by
//   directed and random traffic against a queue-based reference, plus one
//   fall-through instance exercised separately.
module tb_sync_fifo_param;

  localparam int DATA_W    = 16;
  localparam int ADDR_W    = 5;
  localparam int DEPTH     = 32;
  localparam int AFULL_TH  = 28;
  localparam int AEMPTY_TH = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;

  int total = 0;
  int bad   = 0;

  sync_fifo_param_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();
  sync_fifo_param_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) fbus ();

  sync_fifo_param #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .FWFT(0),
    .AFULL_TH(AFULL_TH), .AEMPTY_TH(AEMPTY_TH)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  sync_fifo_param #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .FWFT(1),
    .AFULL_TH(AFULL_TH), .AEMPTY_TH(AEMPTY_TH)
  ) dut_fwft (
    .clk (clk),
    .rst (rst),
    .bus (fbus)
  );

  always #5 clk = ~clk;

  // Reference state: stored words in order, words whose read edge has
  // passed but not yet been seen on the output, sticky errors, last read.
  logic [DATA_W-1:0] model_q [$];
  logic [DATA_W-1:0] exp_q [$];
  logic [DATA_W-1:0] fmodel_q [$];
  bit                m_ovf;
  bit                m_unf;
  logic [DATA_W-1:0] last_rd;

  task automatic checkVal(input string name, input logic [31:0] actual,
                          input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", name, actual, expected);
    end
  endtask

  task automatic checkOutput(input string tag);
    int n;
    n = model_q.size();
    checkVal({tag, ".count"},        32'(bus.count),        32'(n));
    checkVal({tag, ".full"},         32'(bus.full),         32'(n == DEPTH));
    checkVal({tag, ".empty"},        32'(bus.empty),        32'(n == 0));
    checkVal({tag, ".almost_full"},  32'(bus.almost_full),  32'(n >= AFULL_TH));
    checkVal({tag, ".almost_empty"}, 32'(bus.almost_empty), 32'(n <= AEMPTY_TH));
    checkVal({tag, ".overflow"},     32'(bus.overflow),     32'(m_ovf));
    checkVal({tag, ".underflow"},    32'(bus.underflow),    32'(m_unf));
    checkVal({tag, ".rd_data_hold"}, 32'(bus.rd_data),      32'(last_rd));
  endtask

  // One clock of traffic on the registered-read instance. The reference
  // decides acceptance from the occupancy before the edge.
  task automatic applyStimulus(input bit w, input logic [DATA_W-1:0] d,
                               input bit r, input bit f, input string tag);
    bit racc;
    bit wacc;
    int n;
    logic [DATA_W-1:0] popped;
    bus.wr_en   = w;
    bus.wr_data = d;
    bus.rd_en   = r;
    bus.flush   = f;
    racc   = 1'b0;
    popped = '0;
    n = model_q.size();
    if (f) begin
      model_q.delete();
      m_ovf = 1'b0;
      m_unf = 1'b0;
    end else begin
      if (w && n == DEPTH) m_ovf = 1'b1;
      if (r && n == 0)     m_unf = 1'b1;
      racc = r && (n > 0);
      wacc = w && (n < DEPTH);
      if (racc) popped = model_q.pop_front();
      if (wacc) model_q.push_back(d);
    end
    @(posedge clk);
    if (racc) begin
      exp_q.push_back(popped);
      last_rd = popped;
    end
    #1;
    bus.wr_en = 1'b0;
    bus.rd_en = 1'b0;
    bus.flush = 1'b0;
    checkOutput(tag);
  endtask

  // Asserted just after an edge so any read issued on that edge is in flight.
  task automatic doReset(input string tag);
    rst = 1'b1;
    exp_q.delete();
    model_q.delete();
    fmodel_q.delete();
    m_ovf   = 1'b0;
    m_unf   = 1'b0;
    last_rd = '0;
    bus.wr_en  = 1'b0;
    bus.rd_en  = 1'b0;
    bus.flush  = 1'b0;
    fbus.wr_en = 1'b0;
    fbus.rd_en = 1'b0;
    fbus.flush = 1'b0;
    #2;
    checkVal({tag, ".rd_valid"}, 32'(bus.rd_valid), 32'd0);
    checkOutput(tag);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic fwftStep(input bit w, input logic [DATA_W-1:0] d,
                          input bit r, input string tag);
    int n;
    fbus.wr_en   = w;
    fbus.wr_data = d;
    fbus.rd_en   = r;
    fbus.flush   = 1'b0;
    n = fmodel_q.size();
    if (r && n > 0)     void'(fmodel_q.pop_front());
    if (w && n < DEPTH) fmodel_q.push_back(d);
    @(posedge clk);
    #1;
    fbus.wr_en = 1'b0;
    fbus.rd_en = 1'b0;
    n = fmodel_q.size();
    checkVal({tag, ".count"},    32'(fbus.count),    32'(n));
    checkVal({tag, ".empty"},    32'(fbus.empty),    32'(n == 0));
    checkVal({tag, ".rd_valid"}, 32'(fbus.rd_valid), 32'(n > 0));
    if (n > 0) begin
      checkVal({tag, ".rd_data"}, 32'(fbus.rd_data), 32'(fmodel_q[0]));
    end
  endtask

  // Read-side monitor: every read edge must be followed by exactly one
  // rd_valid cycle carrying the oldest outstanding word.
  initial begin
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0 && bus.rd_valid === 1'b1) begin
        checkVal("mon.rd_data", 32'(bus.rd_data), 32'(exp_q.pop_front()));
      end else if (exp_q.size() > 0) begin
        checkVal("mon.rd_valid_missing", 32'(bus.rd_valid), 32'd1);
        void'(exp_q.pop_front());
      end else begin
        checkVal("mon.rd_valid_idle", 32'(bus.rd_valid), 32'd0);
      end
    end
  end

  initial begin
    bit w;
    bit r;
    bit f;
    int wbias;
    bus.flush    = 1'b0;
    bus.wr_en    = 1'b0;
    bus.wr_data  = '0;
    bus.rd_en    = 1'b0;
    fbus.flush   = 1'b0;
    fbus.wr_en   = 1'b0;
    fbus.wr_data = '0;
    fbus.rd_en   = 1'b0;
    m_ovf   = 1'b0;
    m_unf   = 1'b0;
    last_rd = '0;

    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checkVal("reset.rd_valid", 32'(bus.rd_valid), 32'd0);
    checkOutput("reset");
    rst = 1'b0;

    for (int i = 0; i < DEPTH; i++) applyStimulus(1'b1, DATA_W'(i), 1'b0, 1'b0, "fill");
    applyStimulus(1'b1, 16'hBEEF, 1'b0, 1'b0, "fill_over");

    for (int i = 0; i < DEPTH; i++) applyStimulus(1'b0, '0, 1'b1, 1'b0, "drain");
    applyStimulus(1'b0, '0, 1'b1, 1'b0, "drain_under");
    applyStimulus(1'b0, '0, 1'b0, 1'b0, "drain_idle");

    for (int i = 0; i < 5; i++) applyStimulus(1'b1, DATA_W'($urandom), 1'b0, 1'b0, "pre_reset");
    applyStimulus(1'b1, DATA_W'($urandom), 1'b1, 1'b0, "pre_reset_rd");
    doReset("mid_reset");

    for (int i = 0; i < 16; i++) applyStimulus(1'b1, DATA_W'($urandom), 1'b0, 1'b0, "wrap_fill");
    for (int i = 0; i < 100; i++) applyStimulus(1'b1, DATA_W'($urandom), 1'b1, 1'b0, "wrap_simul");
    for (int i = 0; i < 16; i++) applyStimulus(1'b1, DATA_W'($urandom), 1'b0, 1'b0, "wrap_top");
    applyStimulus(1'b1, DATA_W'($urandom), 1'b1, 1'b0, "full_simul");
    checkVal("full_simul.count31", 32'(bus.count), 32'd31);

    doReset("pre_flush");
    for (int i = 0; i < DEPTH; i++) applyStimulus(1'b1, DATA_W'($urandom), 1'b0, 1'b0, "flush_fill");
    applyStimulus(1'b1, DATA_W'($urandom), 1'b0, 1'b0, "flush_over");
    for (int i = 0; i < 22; i++) applyStimulus(1'b0, '0, 1'b1, 1'b0, "flush_read");
    checkVal("flush_setup.count10", 32'(bus.count), 32'd10);
    applyStimulus(1'b1, 16'h1234, 1'b1, 1'b1, "flush");
    checkVal("flush.count0", 32'(bus.count), 32'd0);
    applyStimulus(1'b0, '0, 1'b0, 1'b0, "post_flush");

    for (int blk = 0; blk < 10; blk++) begin
      wbias = (blk % 2 == 1) ? 85 : 25;
      for (int c = 0; c < 40; c++) begin
        w = ($urandom_range(0, 99) < wbias);
        r = ($urandom_range(0, 99) < (110 - wbias));
        f = ($urandom_range(0, 99) == 0);
        applyStimulus(w, DATA_W'($urandom), r, f, "random");
      end
    end

    fwftStep(1'b1, 16'hA5A5, 1'b0, "fwft_write");
    fwftStep(1'b0, '0, 1'b0, "fwft_hold");
    fwftStep(1'b0, '0, 1'b1, "fwft_pop");
    for (int i = 0; i < 120; i++) begin
      w = ($urandom_range(0, 99) < ((i < 60) ? 75 : 35));
      r = ($urandom_range(0, 99) < ((i < 60) ? 35 : 75));
      fwftStep(w, DATA_W'($urandom), r, "fwft_random");
    end

    repeat (3) @(posedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
